// File: rtl/victim_writeback_buffer_pkg.sv
// ----------------------------------------------------------------------------
// victim_writeback_buffer_pkg
// Shared types and constants for the victim writeback buffer slice.
//   line_addr_t : {ptag[43:0], vindex[5:0]} line address
//   block_t     : one evicted 512-bit cache block
//   beat_t      : one 64-bit writeback burst beat
//   wb_state_t  : writeback FSM state encoding
// ----------------------------------------------------------------------------
package victim_writeback_buffer_pkg;

    localparam int DEPTH_DEF   = 4;
    localparam int BLOCK_W_DEF = 512;
    localparam int ADDR_W_DEF  = 50;
    localparam int BEAT_W_DEF  = 64;
    localparam int BEATS       = 8;
    localparam int PTAG_W      = 44;
    localparam int VINDEX_W    = 6;

    typedef logic [49:0]  line_addr_t;
    typedef logic [511:0] block_t;
    typedef logic [63:0]  beat_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wb_state_t;

endpackage

// File: rtl/victim_writeback_buffer_if.sv
// ----------------------------------------------------------------------------
// victim_writeback_buffer_if
// Bundles the eviction input channel, the writeback burst channel, the
// address-lookup probe and the occupancy status of the writeback buffer.
//   master : the cache / downstream side (drives evictions, wb_ready, probe)
//   slave  : the buffer itself
// ----------------------------------------------------------------------------
interface victim_writeback_buffer_if
    import victim_writeback_buffer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int BEAT_W  = BEAT_W_DEF
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               evict_valid;
    logic [ADDR_W-1:0]  evict_addr;
    logic [BLOCK_W-1:0] evict_block;
    logic               evict_ready;

    logic               wb_valid;
    logic [ADDR_W-1:0]  wb_addr;
    logic [BEAT_W-1:0]  wb_data;
    logic               wb_last;
    logic               wb_ready;

    logic [ADDR_W-1:0]  lookup_addr;
    logic               lookup_hit;
    logic [BLOCK_W-1:0] lookup_block;

    logic [CNT_W-1:0]   occupancy;

    modport master (
        output evict_valid, evict_addr, evict_block, wb_ready, lookup_addr,
        input  evict_ready, wb_valid, wb_addr, wb_data, wb_last,
               lookup_hit, lookup_block, occupancy
    );

    modport slave (
        input  evict_valid, evict_addr, evict_block, wb_ready, lookup_addr,
        output evict_ready, wb_valid, wb_addr, wb_data, wb_last,
               lookup_hit, lookup_block, occupancy
    );

endinterface

// File: rtl/victim_writeback_buffer_wb_entry_array.sv
// ----------------------------------------------------------------------------
// wb_entry_array
// DEPTH x {valid, addr, block} storage for the writeback buffer.
//   i_wr_*        : write/overwrite port (sets valid at i_wr_idx)
//   i_clr_en      : clears valid of the head entry (burst completed)
//   i_head_idx    : head pointer; drives head read port and lookup ordering
//   i_excl_en     : exclude head entry from the enqueue address match
//   i_match_addr  : enqueue address; o_match_hit/o_match_idx locate an
//                   overwritable entry
//   o_head_*      : head entry contents
//   i_lookup_addr : probe; o_lookup_hit/o_lookup_block give newest match
// ----------------------------------------------------------------------------
module wb_entry_array #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 50,
    parameter int BLOCK_W = 512,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wr_en,
    input  logic [PTR_W-1:0]   i_wr_idx,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [BLOCK_W-1:0] i_wr_block,
    input  logic               i_clr_en,
    input  logic [PTR_W-1:0]   i_head_idx,
    input  logic               i_excl_en,
    input  logic [ADDR_W-1:0]  i_match_addr,
    output logic               o_match_hit,
    output logic [PTR_W-1:0]   o_match_idx,
    output logic [ADDR_W-1:0]  o_head_addr,
    output logic [BLOCK_W-1:0] o_head_block,
    input  logic [ADDR_W-1:0]  i_lookup_addr,
    output logic               o_lookup_hit,
    output logic [BLOCK_W-1:0] o_lookup_block
);

    logic [DEPTH-1:0]   r_valid;
    logic [ADDR_W-1:0]  r_addr  [DEPTH];
    logic [BLOCK_W-1:0] r_block [DEPTH];

    // Entry valid bits: set on write, cleared when the head burst completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_wr_en && (i_wr_idx == PTR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (i_clr_en && (i_head_idx == PTR_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end else begin
                    r_valid[i] <= r_valid[i];
                end
            end
        end
    end

    // Entry payload; meaningful only while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_addr[i_wr_idx]  <= i_wr_addr;
            r_block[i_wr_idx] <= i_wr_block;
        end
    end

    assign o_head_addr  = r_addr[i_head_idx];
    assign o_head_block = r_block[i_head_idx];

    // Enqueue match: addresses are unique outside the in-flight head, so at
    // most one entry can hit once the head is excluded.
    always_comb begin
        logic w_sel;
        w_sel       = 1'b0;
        o_match_hit = 1'b0;
        o_match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sel       = r_valid[i] && (r_addr[i] == i_match_addr) &&
                          !(i_excl_en && (i_head_idx == PTR_W'(i)));
            o_match_hit = o_match_hit | w_sel;
            o_match_idx = w_sel ? PTR_W'(i) : o_match_idx;
        end
    end

    // Lookup walks oldest (head) to newest so the last hit is the newest copy.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        logic             w_sel;
        w_idx          = '0;
        w_sel          = 1'b0;
        o_lookup_hit   = 1'b0;
        o_lookup_block = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx          = i_head_idx + PTR_W'(i);
            w_sel          = r_valid[w_idx] && (r_addr[w_idx] == i_lookup_addr);
            o_lookup_hit   = o_lookup_hit | w_sel;
            o_lookup_block = w_sel ? r_block[w_idx] : o_lookup_block;
        end
    end

endmodule

// File: rtl/victim_writeback_buffer.sv
// ----------------------------------------------------------------------------
// victim_writeback_buffer
// Queues evicted cache blocks and writes each one back as an 8-beat burst.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears all state and aborts any burst
//   bus   : eviction channel, writeback burst channel, lookup probe and
//           occupancy (see victim_writeback_buffer_if)
// A re-eviction of an address already queued (but not being written back)
// replaces that entry's data in place.
// ----------------------------------------------------------------------------
module victim_writeback_buffer
    import victim_writeback_buffer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BEAT_W  = BEAT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    victim_writeback_buffer_if.slave  bus
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_N = BLOCK_W / BEAT_W;
    localparam int BCNT_W = $clog2(BEAT_N);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEAT_N - 1);

    logic [0:0]         r_state;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [BCNT_W-1:0]  r_beat;

    logic [0:0]         w_state_next;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_full;
    logic               w_in_flight;
    logic               w_push;
    logic               w_alloc;
    logic               w_ovr;
    logic               w_beat_hs;
    logic               w_pop;
    logic               w_match_hit;
    logic [PTR_W-1:0]   w_match_idx;
    logic [PTR_W-1:0]   w_wr_idx;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [BLOCK_W-1:0] w_head_block;

    // Full is taken from the registered count only: a pop in the same cycle
    // does not open a slot.
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_in_flight = (r_state == ST_BURST);
    assign w_push      = bus.evict_valid && !w_full;
    assign w_ovr       = w_push && w_match_hit;
    assign w_alloc     = w_push && !w_match_hit;
    assign w_wr_idx    = w_ovr ? w_match_idx : r_tail;
    assign w_beat_hs   = w_in_flight && bus.wb_ready;
    assign w_pop       = w_beat_hs && (r_beat == LAST_BEAT);
    assign w_count_next = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

    wb_entry_array #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W)
    ) u_entries (
        .clk            (clk),
        .reset          (reset),
        .i_wr_en        (w_push),
        .i_wr_idx       (w_wr_idx),
        .i_wr_addr      (bus.evict_addr),
        .i_wr_block     (bus.evict_block),
        .i_clr_en       (w_pop),
        .i_head_idx     (r_head),
        .i_excl_en      (w_in_flight),
        .i_match_addr   (bus.evict_addr),
        .o_match_hit    (w_match_hit),
        .o_match_idx    (w_match_idx),
        .o_head_addr    (w_head_addr),
        .o_head_block   (w_head_block),
        .i_lookup_addr  (bus.lookup_addr),
        .o_lookup_hit   (bus.lookup_hit),
        .o_lookup_block (bus.lookup_block)
    );

    // Next FSM state: entering/continuing a burst looks at the post-update
    // count so a fresh entry starts next cycle and bursts run back to back.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                w_state_next = (w_count_next != '0) ? ST_BURST : ST_IDLE;
            end
            ST_BURST: begin
                if (w_pop) begin
                    w_state_next = (w_count_next != '0) ? ST_BURST : ST_IDLE;
                end else begin
                    w_state_next = ST_BURST;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pointers, count, beat counter and FSM state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_alloc) begin
                r_tail <= r_tail + PTR_W'(1);
            end else begin
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
                r_beat <= '0;
            end else if (w_beat_hs) begin
                r_head <= r_head;
                r_beat <= r_beat + BCNT_W'(1);
            end else begin
                r_head <= r_head;
                r_beat <= r_beat;
            end
        end
    end

    assign bus.evict_ready = !w_full;
    assign bus.wb_valid    = w_in_flight;
    assign bus.wb_addr     = w_in_flight ? w_head_addr : '0;
    assign bus.wb_data     = w_in_flight ? w_head_block[r_beat*BEAT_W +: BEAT_W] : '0;
    assign bus.wb_last     = w_in_flight && (r_beat == LAST_BEAT);
    assign bus.occupancy   = r_count;

endmodule
